// File: rtl/bin_avg_readout.sv
// bin_avg_readout: counts collector frames, snapshots per-bin sums every 2^LOG2_AVG frames,
// clears the collector and streams saturated averages one bin per valid/ready beat.
module bin_avg_readout #(
  parameter int BINS = 4,
  parameter int N = 16,
  parameter int SUM_WIDTH = 128,
  parameter int LOG2_AVG = 4,
  localparam int BW = BINS > 1 ? $clog2(BINS) : 1
) (
  input  logic                           clk,
  input  logic                           areset_n,
  input  logic [BINS-1:0][SUM_WIDTH-1:0] in_sums,
  input  logic                           frame_done,
  output logic                           clr_sums,
  output logic [N-1:0]                   out_data,
  output logic [BW-1:0]                  out_bin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           overrun
);
  localparam int CW = LOG2_AVG + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << LOG2_AVG) - 1);
  localparam logic [BW-1:0] LAST_BIN = BW'(BINS - 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BINS-1:0][SUM_WIDTH-1:0] snap;
  logic [SUM_WIDTH-1:0] avg;
  logic dump, accept, fin;
  assign dump = frame_done && cnt == CNT_MAX;
  assign out_valid = state == STREAM;
  assign accept = out_valid && out_ready;
  assign fin = accept && out_bin == LAST_BIN;
  assign out_last = out_valid && out_bin == LAST_BIN;
  assign avg = snap[out_bin] >> LOG2_AVG;
  assign out_data = |avg[SUM_WIDTH-1:N] ? '1 : avg[N-1:0];
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      state <= IDLE;
      cnt <= '0;
      snap <= '0;
      out_bin <= '0;
      clr_sums <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= dump ? '0 : cnt + CW'(frame_done);
      clr_sums <= dump;
      if (state == IDLE) begin
        if (dump) begin
          state <= STREAM;
          snap <= in_sums;
          out_bin <= '0;
        end
      end else if (fin) begin
        // a dump landing on the final accept chains straight into the next stream
        out_bin <= '0;
        if (dump) snap <= in_sums;
        else state <= IDLE;
      end else begin
        if (accept) out_bin <= out_bin + 1'b1;
        if (dump) overrun <= 1'b1;
      end
    end
endmodule

// File: tb/tb_bin_avg_readout.sv
// tb_bin_avg_readout: directed checks of averaging, saturation, backpressure, overrun,
// back-to-back streams and asynchronous reset with LOG2_AVG=2, BINS=4.
module tb_bin_avg_readout;
  logic clk = 0;
  logic areset_n = 0;
  logic [3:0][127:0] in_sums = '0;
  logic frame_done = 0;
  logic clr_sums;
  logic [15:0] out_data;
  logic [1:0] out_bin;
  logic out_valid;
  logic out_ready = 0;
  logic out_last;
  logic overrun;
  int total = 0;
  int bad = 0;

  bin_avg_readout #(.BINS(4), .N(16), .SUM_WIDTH(128), .LOG2_AVG(2)) dut (
    .clk(clk), .areset_n(areset_n), .in_sums(in_sums), .frame_done(frame_done),
    .clr_sums(clr_sums), .out_data(out_data), .out_bin(out_bin), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    frame_done = 1;
    for (int i = 0; i < n; i++) tick();
    frame_done = 0;
  endtask

  task automatic sums(input logic [127:0] a, b, c, d);
    in_sums[0] = a;
    in_sums[1] = b;
    in_sums[2] = c;
    in_sums[3] = d;
  endtask

  task automatic beat(input string tag, input logic [1:0] bin, input logic [15:0] data);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_bin"}, out_bin, bin);
    chk({tag, "_data"}, out_data, data);
    chk({tag, "_last"}, out_last, bin == 2'd3);
  endtask

  task automatic drain(input string tag, input logic [15:0] d0, d1, d2, d3);
    out_ready = 1;
    beat(tag, 0, d0); tick();
    beat(tag, 1, d1); tick();
    beat(tag, 2, d2); tick();
    beat(tag, 3, d3); tick();
    chk({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] exp_d [4];
    int acc;
    logic r;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_bin", out_bin, 0);
    chk("rst_clr", clr_sums, 0);
    chk("rst_ovr", overrun, 0);
    tick();
    areset_n = 1;
    tick();

    // basic average
    sums(40, 80, 120, 160);
    out_ready = 1;
    frames(3);
    chk("s1_pre_clr", clr_sums, 0);
    chk("s1_pre_valid", out_valid, 0);
    frames(1);
    chk("s1_clr", clr_sums, 1);
    beat("s1_b0", 0, 10);
    tick();
    chk("s1_clr_off", clr_sums, 0);
    beat("s1_b1", 1, 20); tick();
    beat("s1_b2", 2, 30); tick();
    beat("s1_b3", 3, 40); tick();
    chk("s1_idle", out_valid, 0);
    chk("s1_last_off", out_last, 0);

    // backpressure
    out_ready = 0;
    frames(4);
    exp_d = '{16'd10, 16'd20, 16'd30, 16'd40};
    acc = 0;
    for (int c = 0; c < 100 && acc < 4; c++) begin
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      beat("s2", 2'(acc), exp_d[acc]);
      tick();
      if (r) acc++;
    end
    chk("s2_accepts", acc, 4);
    chk("s2_idle", out_valid, 0);
    chk("s2_ovr", overrun, 0);

    // saturation and exact-max boundary
    sums(128'h3FFFC, 128'h100000, 128'h40000, 128'h7);
    out_ready = 0;
    frames(4);
    drain("s3", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1);

    // overrun: snapshot kept, clr_sums still pulses, flag sticks
    sums(40, 80, 120, 160);
    out_ready = 0;
    frames(4);
    beat("s4_d1", 0, 10);
    sums(4, 4, 4, 4);
    frames(3);
    chk("s4_pre_clr", clr_sums, 0);
    chk("s4_pre_ovr", overrun, 0);
    frames(1);
    chk("s4_clr", clr_sums, 1);
    chk("s4_ovr", overrun, 1);
    beat("s4_hold", 0, 10);
    drain("s4", 10, 20, 30, 40);
    chk("s4_ovr_sticky", overrun, 1);
    areset_n = 0;
    #1;
    chk("s4_ovr_rst", overrun, 0);
    tick();
    areset_n = 1;
    tick();

    // back-to-back: dump coincides with the bin3 accept
    sums(40, 80, 120, 160);
    out_ready = 1;
    frames(4);
    beat("s5_b0", 0, 10);
    sums(4, 8, 12, 16);
    frame_done = 1;
    tick(); beat("s5_b1", 1, 20);
    tick(); beat("s5_b2", 2, 30);
    tick(); beat("s5_b3", 3, 40);
    tick();
    frame_done = 0;
    chk("s5_clr", clr_sums, 1);
    chk("s5_ovr", overrun, 0);
    beat("s5_n0", 0, 1); tick();
    beat("s5_n1", 1, 2); tick();
    beat("s5_n2", 2, 3); tick();
    beat("s5_n3", 3, 4); tick();
    chk("s5_idle", out_valid, 0);
    chk("s5_ovr_end", overrun, 0);

    // reset mid-stream with overrun set and clr_sums high
    sums(40, 80, 120, 160);
    out_ready = 0;
    frames(4);
    out_ready = 1;
    frame_done = 1;
    tick(); tick();
    out_ready = 0;
    tick(); tick();
    frame_done = 0;
    beat("s6_mid", 2, 30);
    chk("s6_clr_hi", clr_sums, 1);
    chk("s6_ovr_hi", overrun, 1);
    #2;
    areset_n = 0;
    #1;
    chk("s6_valid", out_valid, 0);
    chk("s6_ovr", overrun, 0);
    chk("s6_clr", clr_sums, 0);
    chk("s6_bin", out_bin, 0);
    chk("s6_last", out_last, 0);
    chk("s6_data", out_data, 0);
    tick();
    areset_n = 1;
    tick();
    out_ready = 1;
    frames(3);
    chk("s6_pre_valid", out_valid, 0);
    chk("s6_pre_clr", clr_sums, 0);
    frames(1);
    chk("s6_clr_new", clr_sums, 1);
    drain("s6", 10, 20, 30, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
